// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for the CPU's single Avalon-style memory bus.
// Master 0 is instruction fetch, master 1 is load/store. One transaction is
// outstanding at a time: IDLE (arbitrate) -> BUS (drive memory) -> RESP (reads only).
module mips_bus_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0  // 0: round-robin, 1: m1 wins ties
) (
  input  logic        clk,
  input  logic        reset,  // asynchronous, active low

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,

  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;  // granted master index
  logic        last_q, last_d;    // last granted master, for round-robin
  logic        req0, req1;
  logic        winner;
  logic        sel_read, sel_write;
  logic [31:0] sel_address, sel_writedata;
  logic [3:0]  sel_byteenable;
  logic        in_bus, in_resp, done;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Pick the winner of this IDLE cycle; a lone requester always wins.
  always_comb begin
    if (req0 && req1) begin
      winner = (PRIORITY_MODE != 0) ? 1'b1 : ~last_q;
    end else begin
      winner = req1;
    end
  end

  // Route the granted master's request signals.
  always_comb begin
    if (grant_q) begin
      sel_read       = m1_read;
      sel_write      = m1_write;
      sel_address    = m1_address;
      sel_writedata  = m1_writedata;
      sel_byteenable = m1_byteenable;
    end else begin
      sel_read       = m0_read;
      sel_write      = m0_write;
      sel_address    = m0_address;
      sel_writedata  = m0_writedata;
      sel_byteenable = m0_byteenable;
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;  // m0 wins the first tie
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = winner;
          last_d  = winner;
          state_d = StBus;
        end
      end
      StBus: begin
        // A request withdrawn after grant releases the bus rather than hanging.
        if (!(sel_read || sel_write)) begin
          state_d = StIdle;
        end else if (!s_waitrequest) begin
          state_d = sel_write ? StIdle : StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Memory-side and master-side outputs.
  always_comb begin
    in_bus  = (state_q == StBus);
    in_resp = (state_q == StResp);

    // Write and read+write both complete at the memory handshake.
    s_write      = in_bus & sel_write;
    s_read       = in_bus & sel_read & ~sel_write;
    s_address    = in_bus ? sel_address    : 32'h0;
    s_writedata  = in_bus ? sel_writedata  : 32'h0;
    s_byteenable = in_bus ? sel_byteenable : 4'h0;

    done = (in_bus & ~s_waitrequest & sel_write) | in_resp;

    m0_waitrequest = req0 & ~(done & ~grant_q);
    m1_waitrequest = req1 & ~(done & grant_q);
    m0_readdata    = (in_resp & ~grant_q) ? s_readdata : 32'h0;
    m1_readdata    = (in_resp & grant_q)  ? s_readdata : 32'h0;
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: directed vector tables, an async-reset sequence and
// randomized traffic against a transaction-level reference model.
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  be [2];
  logic        rd [2];
  logic        wr [2];
  logic        s_wait;
  logic [31:0] s_rdata;

  // Outputs of dut0 (round-robin) at index 0, dut1 (fixed priority) at index 1.
  logic        wq0 [2];
  logic        wq1 [2];
  logic [31:0] rdat0 [2];
  logic [31:0] rdat1 [2];
  logic [31:0] sa [2];
  logic [31:0] swd [2];
  logic [3:0]  sbe [2];
  logic        sr [2];
  logic        sw [2];

  int errs = 0;
  int checks = 0;

  localparam logic [31:0] D = 32'h3C08BFC0;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.PRIORITY_MODE(0)) dut0 (
    .clk(clk), .reset(reset),
    .m0_address(addr[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_writedata(wdata[0]),
    .m0_byteenable(be[0]), .m0_waitrequest(wq0[0]), .m0_readdata(rdat0[0]),
    .m1_address(addr[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_writedata(wdata[1]),
    .m1_byteenable(be[1]), .m1_waitrequest(wq1[0]), .m1_readdata(rdat1[0]),
    .s_address(sa[0]), .s_read(sr[0]), .s_write(sw[0]), .s_writedata(swd[0]),
    .s_byteenable(sbe[0]), .s_waitrequest(s_wait), .s_readdata(s_rdata)
  );

  mips_bus_arbiter #(.PRIORITY_MODE(1)) dut1 (
    .clk(clk), .reset(reset),
    .m0_address(addr[0]), .m0_read(rd[0]), .m0_write(wr[0]), .m0_writedata(wdata[0]),
    .m0_byteenable(be[0]), .m0_waitrequest(wq0[1]), .m0_readdata(rdat0[1]),
    .m1_address(addr[1]), .m1_read(rd[1]), .m1_write(wr[1]), .m1_writedata(wdata[1]),
    .m1_byteenable(be[1]), .m1_waitrequest(wq1[1]), .m1_readdata(rdat1[1]),
    .s_address(sa[1]), .s_read(sr[1]), .s_write(sw[1]), .s_writedata(swd[1]),
    .s_byteenable(sbe[1]), .s_waitrequest(s_wait), .s_readdata(s_rdata)
  );

  function automatic logic [135:0] outs(int d);
    return {sr[d], sw[d], sa[d], swd[d], sbe[d], wq0[d], wq1[d], rdat0[d], rdat1[d]};
  endfunction

  // Expected output word; eb selects whose payload is on the bus (-1 = none).
  function automatic logic [135:0] mk(logic esr, logic esw, int eb, logic ew0, logic ew1,
                                      logic [31:0] r0, logic [31:0] r1);
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  b;
    a = 32'h0;
    w = 32'h0;
    b = 4'h0;
    if (eb >= 0) begin
      a = addr[eb];
      w = wdata[eb];
      b = be[eb];
    end
    return {esr, esw, a, w, b, ew0, ew1, r0, r1};
  endfunction

  task automatic check(string n, logic [135:0] act, logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          dut;
    logic        rst, r0, w0, r1, w1, swt;
    logic        esr, esw;
    int          ebus;
    logic        ew0, ew1;
    logic [31:0] erd0, erd1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(string n, int d, logic rst, logic r0, logic w0, logic r1,
                               logic w1, logic swt, logic esr, logic esw, int eb,
                               logic ew0, logic ew1, logic [31:0] erd0, logic [31:0] erd1);
    vec_t v;
    v.name = n; v.dut = d; v.rst = rst; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1;
    v.swt = swt; v.esr = esr; v.esw = esw; v.ebus = eb; v.ew0 = ew0; v.ew1 = ew1;
    v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  // Transaction-level reference model: owner = -1 when the bus is free.
  int   m_owner;
  logic m_acc;
  int   m_last;
  logic m_done [2];

  function automatic logic [135:0] model_out();
    logic esr, esw;
    int   eb;
    logic ew [2];
    logic [31:0] er [2];
    esr = 1'b0;
    esw = 1'b0;
    eb  = -1;
    if (m_owner >= 0 && !m_acc) begin
      eb  = m_owner;
      esw = wr[m_owner];
      esr = rd[m_owner] && !wr[m_owner];
    end
    for (int x = 0; x < 2; x++) begin
      m_done[x] = (m_owner == x) && (m_acc || (!s_wait && wr[x]));
      ew[x] = (rd[x] || wr[x]) && !m_done[x];
      er[x] = (m_owner == x && m_acc) ? s_rdata : 32'h0;
    end
    return mk(esr, esw, eb, ew[0], ew[1], er[0], er[1]);
  endfunction

  task automatic model_step(int pm);
    logic q0, q1;
    q0 = rd[0] || wr[0];
    q1 = rd[1] || wr[1];
    if (m_owner < 0) begin
      if (q0 || q1) begin
        if (q0 && q1) m_owner = (pm != 0) ? 1 : 1 - m_last;
        else          m_owner = q1 ? 1 : 0;
        m_last = m_owner;
        m_acc  = 1'b0;
      end
    end else if (!m_acc) begin
      if (!s_wait) begin
        if (wr[m_owner]) m_owner = -1;
        else             m_acc = 1'b1;
      end
    end else begin
      m_owner = -1;
      m_acc   = 1'b0;
    end
  endtask

  task automatic run_random(int d, int n);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int x = 0; x < 2; x++) begin
      rd[x] = 1'b0; wr[x] = 1'b0; m_done[x] = 1'b0;
    end
    m_owner = -1; m_acc = 1'b0; m_last = 1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        model_step(d);
        #1;
      end
      for (int x = 0; x < 2; x++) begin
        if ((rd[x] || wr[x]) && m_done[x]) begin
          rd[x] = 1'b0; wr[x] = 1'b0;
        end
        if (!(rd[x] || wr[x]) && $urandom_range(0, 9) < 4) begin
          int k;
          k = $urandom_range(0, 3);
          addr[x]  = $urandom;
          wdata[x] = $urandom;
          be[x]    = 4'($urandom_range(0, 15));
          rd[x]    = (k != 1);
          wr[x]    = (k == 1 || k == 3);
        end
      end
      s_wait  = ($urandom_range(0, 9) < 3);
      s_rdata = $urandom;
      @(negedge clk);
      check($sformatf("rand_pm%0d[%0d]", d, c), outs(d), model_out());
    end
  endtask

  initial begin
    addr[0] = 32'hBFC00000; wdata[0] = 32'hDEADBEEF; be[0] = 4'h3;
    addr[1] = 32'hBFC0002C; wdata[1] = 32'h00FFFFFF; be[1] = 4'hF;
    rd[0] = 1'b0; wr[0] = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0;
    s_wait = 1'b0; s_rdata = D;

    // m0 read alone
    tbl.push_back(row("A_rst",   0, 0, 0,0,0,0, 0, 0,0,-1, 0,0, 0,0));
    tbl.push_back(row("A_idle",  0, 1, 1,0,0,0, 0, 0,0,-1, 1,0, 0,0));
    tbl.push_back(row("A_bus",   0, 1, 1,0,0,0, 0, 1,0, 0, 1,0, 0,0));
    tbl.push_back(row("A_resp",  0, 1, 1,0,0,0, 0, 0,0,-1, 0,0, D,0));
    tbl.push_back(row("A_done",  0, 1, 0,0,0,0, 0, 0,0,-1, 0,0, 0,0));
    // Round-robin: m0 first, then on the repeated tie m1 first
    tbl.push_back(row("B_rst",   0, 0, 1,0,0,1, 0, 0,0,-1, 1,1, 0,0));
    tbl.push_back(row("B_idle",  0, 1, 1,0,0,1, 0, 0,0,-1, 1,1, 0,0));
    tbl.push_back(row("B_bus0",  0, 1, 1,0,0,1, 0, 1,0, 0, 1,1, 0,0));
    tbl.push_back(row("B_resp0", 0, 1, 1,0,0,1, 0, 0,0,-1, 0,1, D,0));
    tbl.push_back(row("B_tie2",  0, 1, 1,0,0,1, 0, 0,0,-1, 1,1, 0,0));
    tbl.push_back(row("B_bus1",  0, 1, 1,0,0,1, 0, 0,1, 1, 1,0, 0,0));
    tbl.push_back(row("B_idle3", 0, 1, 1,0,0,0, 0, 0,0,-1, 1,0, 0,0));
    tbl.push_back(row("B_bus0b", 0, 1, 1,0,0,0, 0, 1,0, 0, 1,0, 0,0));
    tbl.push_back(row("B_resp0b",0, 1, 1,0,0,0, 0, 0,0,-1, 0,0, D,0));
    // Fixed priority: m1 wins both ties
    tbl.push_back(row("C_rst",   1, 0, 1,0,0,1, 0, 0,0,-1, 1,1, 0,0));
    tbl.push_back(row("C_idle",  1, 1, 1,0,0,1, 0, 0,0,-1, 1,1, 0,0));
    tbl.push_back(row("C_bus1",  1, 1, 1,0,0,1, 0, 0,1, 1, 1,0, 0,0));
    tbl.push_back(row("C_tie2",  1, 1, 1,0,0,1, 0, 0,0,-1, 1,1, 0,0));
    tbl.push_back(row("C_bus1b", 1, 1, 1,0,0,1, 0, 0,1, 1, 1,0, 0,0));
    tbl.push_back(row("C_idle3", 1, 1, 1,0,0,0, 0, 0,0,-1, 1,0, 0,0));
    tbl.push_back(row("C_bus0",  1, 1, 1,0,0,0, 0, 1,0, 0, 1,0, 0,0));
    tbl.push_back(row("C_resp0", 1, 1, 1,0,0,0, 0, 0,0,-1, 0,0, D,0));
    // m1 write stalled for 5 cycles
    tbl.push_back(row("D_rst",   0, 0, 0,0,0,1, 1, 0,0,-1, 0,1, 0,0));
    tbl.push_back(row("D_idle",  0, 1, 0,0,0,1, 1, 0,0,-1, 0,1, 0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(row("D_stall", 0, 1, 0,0,0,1, 1, 0,1, 1, 0,1, 0,0));
    tbl.push_back(row("D_done",  0, 1, 0,0,0,1, 0, 0,1, 1, 0,0, 0,0));
    tbl.push_back(row("D_after", 0, 1, 0,0,0,0, 0, 0,0,-1, 0,0, 0,0));
    // m1 read+write is a write with no response phase
    tbl.push_back(row("E_rst",   0, 0, 0,0,0,0, 0, 0,0,-1, 0,0, 0,0));
    tbl.push_back(row("E_idle",  0, 1, 0,0,1,1, 0, 0,0,-1, 0,1, 0,0));
    tbl.push_back(row("E_bus",   0, 1, 0,0,1,1, 0, 0,1, 1, 0,0, 0,0));
    tbl.push_back(row("E_after", 0, 1, 0,0,0,0, 0, 0,0,-1, 0,0, 0,0));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      reset = tbl[i].rst;
      rd[0] = tbl[i].r0; wr[0] = tbl[i].w0;
      rd[1] = tbl[i].r1; wr[1] = tbl[i].w1;
      s_wait = tbl[i].swt;
      s_rdata = D;
      @(negedge clk);
      check($sformatf("%s[%0d]", tbl[i].name, i), outs(tbl[i].dut),
            mk(tbl[i].esr, tbl[i].esw, tbl[i].ebus, tbl[i].ew0, tbl[i].ew1,
               tbl[i].erd0, tbl[i].erd1));
    end

    // Async reset during BUS of an m0 read, then the held read completes normally
    @(posedge clk); #1;
    reset = 1'b0; rd[0] = 1'b1; wr[0] = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0; s_wait = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("F_idle", outs(0), mk(0, 0, -1, 1, 0, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("F_bus", outs(0), mk(1, 0, 0, 1, 0, 0, 0));
    #1 reset = 1'b0;
    #1 check("F_async", outs(0), mk(0, 0, -1, 1, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("F_re_idle", outs(0), mk(0, 0, -1, 1, 0, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("F_re_bus", outs(0), mk(1, 0, 0, 1, 0, 0, 0));
    @(posedge clk); #1;
    @(negedge clk);
    check("F_re_resp", outs(0), mk(0, 0, -1, 0, 0, D, 0));

    run_random(0, 1500);
    run_random(1, 1500);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master arbiter that shares the CPU's single Avalon-style memory bus between the instruction-fetch port (master 0) and the load/store port (master 1) inside `mips_cpu_bus`. It grants one master at a time, forwards its request to memory, honours the memory's `waitrequest`, and returns read data with a fixed one-cycle memory read latency. Each master sees a standard waitrequest handshake and does not need to know about the other.

## Interface

Parameters:
- `PRIORITY_MODE`, default 0: 0 = round-robin between m0 and m1; 1 = fixed priority with m1 (data) always winning ties.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `m0_address`, `m1_address`  in  32  master byte address
- `m0_read`, `m1_read`  in  1  read request
- `m0_write`, `m1_write`  in  1  write request
- `m0_writedata`, `m1_writedata`  in  32  write data
- `m0_byteenable`, `m1_byteenable`  in  4  byte lanes
- `m0_waitrequest`, `m1_waitrequest`  out  1  stall to master; low = transaction complete this cycle
- `m0_readdata`, `m1_readdata`  out  32  read data, valid when that master's read completes
- `s_address`  out  32  to memory
- `s_read`, `s_write`  out  1  to memory
- `s_writedata`  out  32  to memory
- `s_byteenable`  out  4  to memory
- `s_waitrequest`  in  1  memory stall
- `s_readdata`  in  32  memory read data, valid the cycle after a read is accepted

## Operation

- A master requests when `read` or `write` is high. It holds all request signals stable until its `waitrequest` is low.
- If `read` and `write` are both high, the transaction is a write and `read` is ignored.
- FSM states:
  - IDLE: no bus activity. If any master requests, the winner is registered into `grant` and the FSM goes to BUS. With no requests, it stays in IDLE.
  - BUS: `s_*` are driven combinationally from the granted master's inputs.
    - `s_waitrequest`=1: stay in BUS.
    - `s_waitrequest`=0 on a write: the write completes this cycle; go to IDLE.
    - `s_waitrequest`=0 on a read: the read is accepted; go to RESP.
  - RESP: `s_read`/`s_write`=0. The granted master's `readdata` = `s_readdata` (pass-through) and its `waitrequest`=0. Go to IDLE.
- Arbitration:
  - Round-robin: the pointer `last` records the last granted master. On a tie, the master other than `last` wins. `last` updates when a grant is registered.
  - `PRIORITY_MODE`=1: m1 wins any tie and `last` is ignored.
  - A single requester always wins.
- `mX_waitrequest` = 1 whenever mX is requesting and is not in its completion cycle. Otherwise it is 0. It is combinational from state, grant, `s_waitrequest` and the request inputs.
- `mX_readdata` = `s_readdata` when mX is granted and the FSM is in RESP, else 0.
- Outside BUS, `s_read`=`s_write`=0 and `s_address`/`s_writedata`/`s_byteenable`=0.
- No queuing and no reordering; at most one transaction is outstanding.

## Timing

- Reset (async, `reset`=0):
  - FSM goes to IDLE, `grant`=m0, `last`=m1, so m0 wins the first round-robin tie.
  - All `s_*` outputs are 0 immediately.
  - `mX_readdata`=0.
  - `mX_waitrequest`=1 if mX is requesting.
- Write latency, from request seen in IDLE: 2 cycles minimum (IDLE, BUS). Each stalled cycle adds 1.
- Read latency: 3 cycles minimum (IDLE, BUS, RESP). Each stalled cycle adds 1.
- One IDLE cycle always separates consecutive transactions, including back-to-back requests from the same master.
- A losing master stays stalled (`waitrequest`=1) and is re-arbitrated in the next IDLE cycle.
- A request withdrawn in IDLE before a grant is registered is legal. A request withdrawn after its grant is a protocol violation; the behaviour is undefined but must not hang the FSM past the memory handshake.
- Reset asserted mid-transaction (BUS or RESP):
  - The transaction is abandoned and the bus is released at once.
  - Masters must reissue the request; a held request is re-arbitrated after release.

## Test plan

- m0 read of 0xBFC00000 only, memory returns 0x3C08BFC0, no stalls.
  - `s_read`=1 in cycle 2.
  - `m0_readdata`=0x3C08BFC0 with `m0_waitrequest`=0 in cycle 3.
  - m1 outputs stay idle throughout.
- After reset, m0 read and m1 write (0xBFC0002C, data 0x00FFFFFF, byteenable 0xF) issued simultaneously, `PRIORITY_MODE`=0.
  - m0 is served first and m1 second.
  - Repeating the same simultaneous requests serves m1 first.
- Same stimulus with `PRIORITY_MODE`=1: m1 is served first on every repetition.
- m1 write with `s_waitrequest` held high for 5 cycles.
  - `s_write`, address, data and byteenable stay stable for 6 BUS cycles.
  - `m1_waitrequest` is high until the 6th BUS cycle, where it is 0.
- `reset`=0 asynchronously during BUS of an m0 read.
  - `s_read` drops to 0 before the next clock edge and the FSM is in IDLE.
  - After release with m0 still requesting, the read completes normally in 3 cycles.
- m1 with `read`=`write`=1: a write is issued (`s_write`=1, `s_read`=0), no RESP state is entered, and `m1_readdata` stays 0.
